// File: rtl/serial_sub.sv
// Bit-serial subtractor: A - B - bin over WIDTH cycles, LSB first, one
// full-subtractor cell with start/ready/done handshake and held result.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic [WIDTH:0]   out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  sa_reg;
    logic [WIDTH-1:0]  sb_reg;
    logic [WIDTH-1:0]  work_reg;
    logic [WIDTH-1:0]  work_next;
    logic [WIDTH-1:0]  diff_reg;
    logic              br_reg;
    logic              bout_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              d_bit;
    logic              br_next;
    logic              last_bit;

    // Single full-subtractor cell operating on the current LSBs.
    assign d_bit     = sa_reg[0] ^ sb_reg[0] ^ br_reg;
    assign br_next   = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);
    assign work_next = {d_bit, work_reg[WIDTH-1:1]};
    assign last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs come from registered state only; rst just masks ready.
    always_comb begin
        ready = (state_reg == IDLE) && !rst;
        done  = (state_reg == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_reg   <= '0;
            sb_reg   <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            work_reg <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sa_reg  <= a;
                        sb_reg  <= b;
                        br_reg  <= bin;
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    sa_reg   <= sa_reg >> 1;
                    sb_reg   <= sb_reg >> 1;
                    br_reg   <= br_next;
                    work_reg <= work_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    // Publish only a complete result, so the outputs hold otherwise.
                    if (last_bit) begin
                        diff_reg <= work_next;
                        bout_reg <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign out  = {bout_reg, diff_reg};

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=4 and WIDTH=16: stimulus pushes
// expected results, per-instance monitors pop and compare on done.
module tb_serial_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, bin4, start16, bin16;
    logic [3:0]  a4, b4;
    logic [15:0] a16, b16;
    logic        ready4, done4, bout4, ready16, done16, bout16;
    logic [3:0]  diff4;
    logic [4:0]  out4;
    logic [15:0] diff16;
    logic [16:0] out16;

    int total = 0;
    int bad   = 0;

    logic [4:0]  q4[$];
    logic [16:0] q16[$];
    logic [4:0]  held4  = '0;
    logic [16:0] held16 = '0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .done(done4), .diff(diff4), .bout(bout4), .out(out4)
    );

    serial_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .ready(ready16), .done(done16), .diff(diff16), .bout(bout16), .out(out16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: result on done, and out must equal the last expected result every cycle.
    always @(negedge clk) begin
        if (rst) begin
            held4 = '0;
        end else begin
            if (done4) begin
                if (q4.size() == 0) begin
                    check("unexpected_done4", 32'(done4), 32'(0));
                end else begin
                    held4 = q4.pop_front();
                    check("diff4", 32'(diff4), 32'(held4[3:0]));
                    check("bout4", 32'(bout4), 32'(held4[4]));
                    $display("w4 result out=%b", out4);
                end
            end
            check("out4_hold", 32'(out4), 32'(held4));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held16 = '0;
        end else begin
            if (done16) begin
                if (q16.size() == 0) begin
                    check("unexpected_done16", 32'(done16), 32'(0));
                end else begin
                    held16 = q16.pop_front();
                    check("diff16", 32'(diff16), 32'(held16[15:0]));
                    check("bout16", 32'(bout16), 32'(held16[16]));
                end
            end
            check("out16_hold", 32'(out16), 32'(held16));
        end
    end

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi, input logic [4:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready4 && n < 20) begin @(negedge clk); n++; end
        check("ready4_wait", 32'(ready4), 32'(1));
        #1;
        a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
        q4.push_back(exp);
        $display("w4 op a=%b b=%b bin=%b exp=%b", a, b, bi, exp);
        @(negedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        n = 1;
        while (!done4 && n < 20) begin @(negedge clk); n++; end
        check("latency4", 32'(n), 32'(5));
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready16 && n < 40) begin @(negedge clk); n++; end
        check("ready16_wait", 32'(ready16), 32'(1));
        #1;
        a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
        q16.push_back(17'({1'b0, a} - {1'b0, b} - 17'(bi)));
        @(negedge clk);
        #1;
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        n = 1;
        while (!done16 && n < 40) begin @(negedge clk); n++; end
        check("latency16", 32'(n), 32'(17));
    endtask

    initial begin
        int prev, dones, c;
        rst = 1'b1;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start16 = 0; a16 = 0; b16 = 0; bin16 = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready4", 32'(ready4), 32'(0));
        check("rst_done4", 32'(done4), 32'(0));
        check("rst_out4", 32'(out4), 32'(0));
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready4", 32'(ready4), 32'(1));
        check("post_rst_ready16", 32'(ready16), 32'(1));

        // Directed vectors
        op4(4'b1010, 4'b1100, 1'b0, 5'b11110);
        op4(4'b1111, 4'b1111, 1'b0, 5'b00000);
        op4(4'b1101, 4'b0110, 1'b0, 5'b00111);
        op4(4'b0000, 4'b0000, 1'b1, 5'b11111);

        // Extra starts during RUN are ignored
        @(negedge clk);
        #1 start4 = 1; a4 = 4'b1010; b4 = 4'b1100; bin4 = 0;
        q4.push_back(5'b11110);
        @(negedge clk); #1 start4 = 0;
        @(negedge clk); #1 start4 = 1; a4 = 4'b0001; b4 = 4'b0001;
        @(negedge clk); #1 start4 = 0;
        @(negedge clk); #1 start4 = 1;
        @(negedge clk);
        check("ignored_done4", 32'(done4), 32'(1));
        #1 start4 = 0;
        repeat (8) @(negedge clk);
        check("ignored_queue4", 32'(q4.size()), 32'(0));

        // start held high: back-to-back operations every 6 cycles
        #1 start4 = 1; a4 = 4'b1101; b4 = 4'b0110; bin4 = 0;
        repeat (3) q4.push_back(5'b00111);
        prev = -1; dones = 0; c = 0;
        while (dones < 3 && c < 60) begin
            @(negedge clk);
            c++;
            if (done4) begin
                if (prev >= 0) check("period4", 32'(c - prev), 32'(6));
                prev = c;
                dones++;
            end
        end
        #1 start4 = 0;
        check("held_dones4", 32'(dones), 32'(3));

        // Reset in the middle of RUN discards the partial result
        @(negedge clk);
        #1 start4 = 1; a4 = 4'b1101; b4 = 4'b0110; bin4 = 0;
        @(negedge clk); #1 start4 = 0;
        @(negedge clk); #1 rst = 1;
        #1;
        check("midrst_out4", 32'(out4), 32'(0));
        check("midrst_ready4", 32'(ready4), 32'(0));
        check("midrst_done4", 32'(done4), 32'(0));
        @(negedge clk); #1 rst = 0;
        @(negedge clk);
        check("midrst_ready_after", 32'(ready4), 32'(1));
        check("midrst_out_after", 32'(out4), 32'(0));
        repeat (8) @(negedge clk);
        op4(4'b0101, 4'b0011, 1'b0, 5'b00010);

        // Exhaustive sweep at WIDTH=4
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ta, tb;
            logic       tbi;
            ta  = 4'(i >> 5);
            tb  = 4'(i >> 1);
            tbi = 1'(i);
            op4(ta, tb, tbi, 5'({1'b0, ta} - {1'b0, tb} - 5'(tbi)));
        end

        // Random vectors at WIDTH=16, plus edge operands
        op16(16'h0000, 16'h0000, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        op16(16'h0000, 16'hFFFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("final_queue4", 32'(q4.size()), 32'(0));
        check("final_queue16", 32'(q16.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
